// File: rtl/dec_err_correct.sv
// SECDED error-correction back end: classifies a latched syndrome and,
// for a single error, serially searches the H columns for the bit to flip.
// Optional macro ERR_CNT_EN adds saturating corrected/uncorrectable counters;
// without it cnt_corr and cnt_uncorr are constant 0.
//
// state  | meaning
// IDLE   | waiting for start; results held
// CHECK  | classify latched syndrome (zero / double / invalid / single)
// SEARCH | compare H column idx with syndrome, one column per clock
module dec_err_correct #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [MAX_CODEWORD_WIDTH-1:0]              codeword_in,
  input  logic [MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH-1:0] syndrome_in,
  input  logic [1:0]                                 work_mod,
  output logic                                       busy,
  output logic                                       done,
  output logic [MAX_CODEWORD_WIDTH-1:0]              data_out,
  output logic [1:0]                                 err_num,
  output logic [4:0]                                 err_pos,
  output logic [15:0]                                cnt_corr,
  output logic [15:0]                                cnt_uncorr
);

  localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

  typedef enum logic [1:0] {IDLE, CHECK, SEARCH} state_t;

  state_t      state_q, state_n;
  logic [4:0]  idx_q, idx_n;
  logic [31:0] cw_q, cw_n;
  logic [5:0]  syn_q, syn_n;
  logic [1:0]  mode_q, mode_n;
  logic [31:0] data_q, data_n;
  logic [1:0]  err_q, err_n;
  logic [4:0]  pos_q, pos_n;
  logic        done_q, done_n;

  // Column idx of the H matrix for a mode; rows beyond P read as 0 so the
  // column compares directly against the masked 6-bit syndrome.
  function automatic logic [5:0] h_col(input logic [1:0] m, input logic [4:0] idx);
    logic [31:0] r0, r1, r2, r3, r4, r5;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0;
    case (m)
      2'b00: begin
        r0 = 32'hB1; r1 = 32'hD2; r2 = 32'hE4; r3 = 32'hFF;
      end
      2'b01: begin
        r0 = 32'hAB61; r1 = 32'hCDA2; r2 = 32'hF1C4; r3 = 32'hFE08; r4 = 32'hFFFF;
      end
      2'b10: begin
        r0 = 32'hAAAB56C1; r1 = 32'hCCCD9B42; r2 = 32'hF0F1E384;
        r3 = 32'hFF01FC08; r4 = 32'hFFFE0010; r5 = 32'hFFFFFFFF;
      end
      default: ;
    endcase
    return {r5[idx], r4[idx], r3[idx], r2[idx], r1[idx], r0[idx]};
  endfunction

  function automatic logic [5:0] syn_mask(input logic [1:0] m);
    case (m)
      2'b00:   return 6'h0F;
      2'b01:   return 6'h1F;
      default: return 6'h3F;
    endcase
  endfunction

  // Overall-parity row is the top syndrome bit of the active mode.
  function automatic logic [5:0] par_bit(input logic [1:0] m);
    case (m)
      2'b00:   return 6'h08;
      2'b01:   return 6'h10;
      default: return 6'h20;
    endcase
  endfunction

  function automatic logic [31:0] cw_mask(input logic [1:0] m);
    case (m)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [4:0] last_idx(input logic [1:0] m);
    case (m)
      2'b00:   return 5'd7;
      2'b01:   return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  // A mode is usable only if the configured codeword width can hold it.
  function automatic logic mode_ok(input logic [1:0] m);
    case (m)
      2'b00:   return MAX_CODEWORD_WIDTH >= 8;
      2'b01:   return MAX_CODEWORD_WIDTH >= 16;
      2'b10:   return MAX_CODEWORD_WIDTH >= 32;
      default: return 1'b0;
    endcase
  endfunction

  // The done cycle still counts as busy so a coincident start is dropped.
  assign busy     = (state_q != IDLE) || done_q;
  assign done     = done_q;
  assign data_out = data_q[MAX_CODEWORD_WIDTH-1:0];
  assign err_num  = err_q;
  assign err_pos  = pos_q;

  // Next-state and result logic for the classify/search sequence.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cw_n    = cw_q;
    syn_n   = syn_q;
    mode_n  = mode_q;
    data_n  = data_q;
    err_n   = err_q;
    pos_n   = pos_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          cw_n    = 32'(codeword_in) & cw_mask(work_mod);
          syn_n   = 6'(syndrome_in) & syn_mask(work_mod);
          mode_n  = work_mod;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (!mode_ok(mode_q)) begin
          err_n = 2'b11; data_n = '0; pos_n = '0; done_n = 1'b1; state_n = IDLE;
        end else if (syn_q == 6'd0) begin
          err_n = 2'b00; data_n = cw_q; pos_n = '0; done_n = 1'b1; state_n = IDLE;
        end else if ((syn_q & par_bit(mode_q)) == 6'd0) begin
          err_n = 2'b10; data_n = cw_q; pos_n = '0; done_n = 1'b1; state_n = IDLE;
        end else begin
          idx_n   = '0;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (h_col(mode_q, idx_q) == syn_q) begin
          err_n   = 2'b01;
          data_n  = cw_q ^ (32'd1 << idx_q);
          pos_n   = idx_q;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (idx_q == last_idx(mode_q)) begin
          err_n   = 2'b10;
          data_n  = cw_q;
          pos_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          idx_n = idx_q + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and result registers; reset wins over any in-flight search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cw_q    <= '0;
      syn_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cw_q    <= cw_n;
      syn_q   <= syn_n;
      mode_q  <= mode_n;
      data_q  <= data_n;
      err_q   <= err_n;
      pos_q   <= pos_n;
      done_q  <= done_n;
    end
  end

`ifdef ERR_CNT_EN
  logic [15:0] cnt_corr_q, cnt_uncorr_q;

  // Saturating event counters, bumped on the done pulse of each result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else if (done_q) begin
      if (err_q == 2'b01 && cnt_corr_q != 16'hFFFF)
        cnt_corr_q <= cnt_corr_q + 16'd1;
      if (err_q == 2'b10 && cnt_uncorr_q != 16'hFFFF)
        cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
    end
  end

  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;
`else
  assign cnt_corr   = '0;
  assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_dec_err_correct.sv
// Scoreboard bench for dec_err_correct: stimulus pushes hand-computed
// results, a negedge monitor pops and checks them whenever done pulses.
module tb_dec_err_correct;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] codeword_in;
  logic [5:0]  syndrome_in;
  logic [1:0]  work_mod;
  logic        busy, done;
  logic [31:0] data_out;
  logic [1:0]  err_num;
  logic [4:0]  err_pos;
  logic [15:0] cnt_corr, cnt_uncorr;

  dec_err_correct dut (
    .clk(clk), .rst(rst), .start(start), .codeword_in(codeword_in),
    .syndrome_in(syndrome_in), .work_mod(work_mod), .busy(busy), .done(done),
    .data_out(data_out), .err_num(err_num), .err_pos(err_pos),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  err;
    logic [4:0]  pos;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int tests = 0, failed = 0, dones = 0;
  int exp_corr = 0, exp_uncorr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, data_out, e.data);
        check({e.name, "_err"}, 32'(err_num), 32'(e.err));
        check({e.name, "_pos"}, 32'(err_pos), 32'(e.pos));
        check({e.name, "_lat"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  // Issue one request from a negedge and wait (bounded) for its done.
  task automatic run(input string name, input logic [1:0] m, input logic [31:0] cw,
                     input logic [5:0] syn, input logic [31:0] ed, input logic [1:0] ee,
                     input logic [4:0] ep, input int lat, input bit poke, input bit coin);
    exp_t e;
    int n;
    e.name = name; e.data = ed; e.err = ee; e.pos = ep; e.lat = lat; e.issue = cyc + 1;
    sb.push_back(e);
    if (ee == 2'b01) exp_corr++;
    if (ee == 2'b10) exp_uncorr++;
    work_mod = m; codeword_in = cw; syndrome_in = syn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (poke && n == 10) begin
        work_mod = 2'b00; codeword_in = 32'h55; syndrome_in = 6'h0;
      end
      start = poke && (n == 10);
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1) begin
      failed++;
      $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
    end
    if (coin) begin
      work_mod = 2'b00; codeword_in = 32'h0; syndrome_in = 6'h0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check({name, "_coin_busy"}, 32'(busy), 32'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; codeword_in = '0; syndrome_in = '0; work_mod = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_err", 32'(err_num), 32'd0);
    check("rst_pos", 32'(err_pos), 32'd0);
    check("rst_cnt_corr", 32'(cnt_corr), 32'd0);
    check("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //   name            mode   cw            syn    data          err    pos    lat poke coin
    run("m0_zero",       2'b00, 32'h00,       6'h00, 32'h00,       2'b00, 5'd0,  1,  0, 0);
    run("m0_bit0",       2'b00, 32'h01,       6'h09, 32'h00,       2'b01, 5'd0,  2,  0, 0);
    run("m0_synmask",    2'b00, 32'h02,       6'h39, 32'h03,       2'b01, 5'd0,  2,  0, 0);
    run("m0_bit5",       2'b00, 32'h3C,       6'h0D, 32'h1C,       2'b01, 5'd5,  7,  0, 0);
    run("m0_bit7",       2'b00, 32'h80,       6'h0F, 32'h00,       2'b01, 5'd7,  9,  0, 0);
    run("m0_cwmask",     2'b00, 32'h1A5,      6'h00, 32'hA5,       2'b00, 5'd0,  1,  0, 0);
    run("m1_double",     2'b01, 32'h1234,     6'h03, 32'h1234,     2'b10, 5'd0,  1,  0, 0);
    run("m1_bit11",      2'b01, 32'h0000,     6'h1B, 32'h0800,     2'b01, 5'd11, 13, 0, 0);
    run("m3_invalid",    2'b11, 32'hAB,       6'h01, 32'h00,       2'b11, 5'd0,  1,  0, 0);
    run("m2_bit0",       2'b10, 32'hFFFFFFFF, 6'h21, 32'hFFFFFFFE, 2'b01, 5'd0,  2,  0, 0);
    run("m2_double",     2'b10, 32'h12345678, 6'h1F, 32'h12345678, 2'b10, 5'd0,  1,  0, 0);
    run("m2_bit31",      2'b10, 32'h80000000, 6'h3F, 32'h00000000, 2'b01, 5'd31, 33, 1, 1);

`ifdef ERR_CNT_EN
    check("cnt_corr", 32'(cnt_corr), 32'(exp_corr));
    check("cnt_uncorr", 32'(cnt_uncorr), 32'(exp_uncorr));
`else
    check("cnt_corr_off", 32'(cnt_corr), 32'd0);
    check("cnt_uncorr_off", 32'(cnt_uncorr), 32'd0);
`endif

    // Reset while the mode10 search sits at idx=5: request is dropped.
    d0 = dones;
    work_mod = 2'b10; codeword_in = 32'h80000000; syndrome_in = 6'h3F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", data_out, 32'd0);
    check("midrst_err", 32'(err_num), 32'd0);
    check("midrst_pos", 32'(err_pos), 32'd0);
    check("midrst_cnt_corr", 32'(cnt_corr), 32'd0);
    check("midrst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_done", 32'(dones - d0), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
